// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared direction and mode encodings for the phase counter
package counter_pkg;
    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;
    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;
endpackage

// File: rtl/prescaler.sv
// rtl/prescaler.sv - divides enabled clk cycles down to one count tick every PRESCALE cycles
module prescaler #(
    parameter int PRESCALE = 1,
    parameter int PW       = $clog2(PRESCALE) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = en & (count == LAST);
endmodule

// File: rtl/updown_counter_mod.sv
// rtl/updown_counter_mod.sv - prescaled up/down counter with load, modulo limit, wrap/one-shot and tc pulse
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int N        = 11,
    parameter int PRESCALE = 1,
    localparam int PW      = $clog2(PRESCALE) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic         dir,
    input  logic         mode,
    input  logic [N-1:0] value,
    input  logic [N-1:0] limit,
    output logic [N-1:0] out,
    output logic         tc,
    output logic         done
);
    logic tick;
    logic step;
    logic at_top;
    logic at_zero;

    prescaler #(
        .PRESCALE(PRESCALE),
        .PW      (PW)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .clr (load),
        .en  (en),
        .tick(tick)
    );

    // >= rather than == so a loaded value above limit still terminates on the next up step
    assign at_top  = (out >= limit);
    assign at_zero = (out == '0);
    assign step    = tick & ~load & ~done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out  <= '0;
            tc   <= 1'b0;
            done <= 1'b0;
        end else if (load) begin
            out  <= value;
            tc   <= 1'b0;
            done <= 1'b0;
        end else if (step) begin
            if (dir == DIR_UP) begin
                if (at_top) begin
                    tc <= 1'b1;
                    if (mode == MODE_ONESHOT) begin
                        out  <= limit;
                        done <= 1'b1;
                    end else begin
                        out <= '0;
                    end
                end else begin
                    out <= out + 1'b1;
                    tc  <= 1'b0;
                end
            end else begin
                if (at_zero) begin
                    tc <= 1'b1;
                    if (mode == MODE_ONESHOT) begin
                        done <= 1'b1;
                    end else begin
                        out <= limit;
                    end
                end else begin
                    out <= out - 1'b1;
                    tc  <= 1'b0;
                end
            end
        end else begin
            tc <= 1'b0;
        end
    end
endmodule

// File: tb/tb_updown_counter_mod.sv
// tb/tb_updown_counter_mod.sv - self-checking bench for updown_counter_mod against a behavioural model
module tb_updown_counter_mod;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        en = 1'b0;
    logic        dir = 1'b0;
    logic        mode = 1'b0;
    logic [10:0] value = '0;
    logic [10:0] limit = '0;
    logic [3:0]  out_a;
    logic        tc_a, done_a;
    logic [10:0] out_b;
    logic        tc_b, done_b;

    int checks = 0;
    int errors = 0;

    // instance 0: N=4, no prescale; instance 1: N=11, prescale by 4
    int NB [2] = '{4, 11};
    int PS [2] = '{1, 4};
    int m_out [2];
    int m_ph  [2];
    bit m_tc  [2];
    bit m_done[2];

    logic [10:0] obs_out [2];
    logic [1:0]  obs_tc, obs_done;
    assign obs_out[0] = {7'b0, out_a};
    assign obs_out[1] = out_b;
    assign obs_tc     = {tc_b, tc_a};
    assign obs_done   = {done_b, done_a};

    updown_counter_mod #(.N(4), .PRESCALE(1)) dut_a (
        .clk(clk), .rst(rst), .load(load), .en(en), .dir(dir), .mode(mode),
        .value(value[3:0]), .limit(limit[3:0]), .out(out_a), .tc(tc_a), .done(done_a)
    );

    updown_counter_mod #(.N(11), .PRESCALE(4)) dut_b (
        .clk(clk), .rst(rst), .load(load), .en(en), .dir(dir), .mode(mode),
        .value(value), .limit(limit), .out(out_b), .tc(tc_b), .done(done_b)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_out[k] = 0; m_ph[k] = 0; m_tc[k] = 0; m_done[k] = 0;
        end
    endtask

    // next state of each counter from the current inputs, applied at the coming edge
    task automatic model_edge();
        int  mask, lim, val;
        bit  stepping;
        for (int k = 0; k < 2; k++) begin
            mask = (1 << NB[k]) - 1;
            lim  = int'(limit) & mask;
            val  = int'(value) & mask;
            if (rst) begin
                m_out[k] = 0; m_ph[k] = 0; m_tc[k] = 0; m_done[k] = 0;
            end else if (load) begin
                m_out[k] = val; m_ph[k] = 0; m_tc[k] = 0; m_done[k] = 0;
            end else begin
                stepping = en && !m_done[k] && (m_ph[k] == PS[k] - 1);
                if (en) m_ph[k] = (m_ph[k] + 1) % PS[k];
                m_tc[k] = 0;
                if (stepping) begin
                    if (dir == 1'b0) begin
                        if (m_out[k] >= lim) begin
                            m_tc[k] = 1;
                            if (mode) begin m_out[k] = lim; m_done[k] = 1; end
                            else m_out[k] = 0;
                        end else m_out[k] = m_out[k] + 1;
                    end else begin
                        if (m_out[k] == 0) begin
                            m_tc[k] = 1;
                            if (mode) m_done[k] = 1;
                            else m_out[k] = lim;
                        end else m_out[k] = m_out[k] - 1;
                    end
                end
            end
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 0; en = 0; dir = 0; mode = 0; value = 0; limit = 11'd9;
        model_reset();
        cyc();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_out[k] !== 11'd0 || obs_tc[k] !== 1'b0 || obs_done[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_initial[%0d]: out=%0d tc=%b done=%b expected 0/0/0", k, obs_out[k], obs_tc[k], obs_done[k]);
            end
        end
        rst = 1'b0;
        value = 11'd5; load = 1'b1; cyc();
        load = 1'b0; en = 1'b1; cyc(); cyc();
        #2 rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_out[k] !== 11'd0 || obs_tc[k] !== 1'b0 || obs_done[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_async[%0d]: out=%0d tc=%b done=%b expected 0/0/0", k, obs_out[k], obs_tc[k], obs_done[k]);
            end
        end
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_out[k] !== 11'(m_out[k]) || obs_tc[k] !== m_tc[k] || obs_done[k] !== m_done[k]) begin
                    errors++;
                    $display("FAIL reset_resume[%0d] c%0d: out=%0d tc=%b done=%b expected %0d/%b/%b", k, i, obs_out[k], obs_tc[k], obs_done[k], m_out[k], m_tc[k], m_done[k]);
                end
            end
        end
    endtask

    task automatic test_up_wrap();
        int exp_a [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        value = 0; limit = 11'd9; mode = 0; dir = 0; en = 0;
        load = 1'b1; cyc(); load = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            checks++;
            if (out_a !== 4'(exp_a[i]) || tc_a !== (exp_a[i] == 0)) begin
                errors++;
                $display("FAIL up_wrap_a c%0d: out=%0d tc=%b expected %0d/%b", i, out_a, tc_a, exp_a[i], exp_a[i] == 0);
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_out[k] !== 11'(m_out[k]) || obs_tc[k] !== m_tc[k] || obs_done[k] !== m_done[k]) begin
                    errors++;
                    $display("FAIL up_wrap[%0d] c%0d: out=%0d tc=%b done=%b expected %0d/%b/%b", k, i, obs_out[k], obs_tc[k], obs_done[k], m_out[k], m_tc[k], m_done[k]);
                end
            end
        end
    endtask

    task automatic test_down_oneshot();
        int tc_count = 0;
        limit = 11'd9; value = 11'd3; mode = 1'b1; dir = 1'b1; en = 1'b1;
        load = 1'b1; cyc(); load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) mode = 1'b0;
            cyc();
            if (tc_a) tc_count++;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_out[k] !== 11'(m_out[k]) || obs_tc[k] !== m_tc[k] || obs_done[k] !== m_done[k]) begin
                    errors++;
                    $display("FAIL down_oneshot[%0d] c%0d: out=%0d tc=%b done=%b expected %0d/%b/%b", k, i, obs_out[k], obs_tc[k], obs_done[k], m_out[k], m_tc[k], m_done[k]);
                end
            end
        end
        checks++;
        if (tc_count != 1 || out_a !== 4'd0 || done_a !== 1'b1) begin
            errors++;
            $display("FAIL down_oneshot_hold_a: tc_pulses=%0d out=%0d done=%b expected 1/0/1", tc_count, out_a, done_a);
        end
        value = 11'd5; load = 1'b1; cyc(); load = 1'b0;
        checks++;
        if (out_a !== 4'd5 || done_a !== 1'b0 || out_b !== 11'd5 || done_b !== 1'b0) begin
            errors++;
            $display("FAIL down_oneshot_reload: out_a=%0d done_a=%b out_b=%0d done_b=%b expected 5/0/5/0", out_a, done_a, out_b, done_b);
        end
    endtask

    task automatic test_prescaler();
        limit = 11'd15; value = 0; mode = 0; dir = 0; en = 1'b1;
        load = 1'b1; cyc(); load = 1'b0;
        for (int i = 0; i < 30; i++) begin
            en = !(i == 9 || i == 10);
            if (i == 18) begin value = 11'd2; load = 1'b1; end
            else load = 1'b0;
            cyc();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_out[k] !== 11'(m_out[k]) || obs_tc[k] !== m_tc[k] || obs_done[k] !== m_done[k]) begin
                    errors++;
                    $display("FAIL prescaler[%0d] c%0d: out=%0d tc=%b done=%b expected %0d/%b/%b", k, i, obs_out[k], obs_tc[k], obs_done[k], m_out[k], m_tc[k], m_done[k]);
                end
            end
        end
        load = 1'b0; en = 1'b1;
    endtask

    task automatic test_load_priority();
        limit = 11'd9; value = 11'd12; mode = 0; dir = 0; en = 1'b1;
        load = 1'b1; cyc(); load = 1'b0;
        checks++;
        if (out_a !== 4'd12 || tc_a !== 1'b0 || out_b !== 11'd12 || tc_b !== 1'b0) begin
            errors++;
            $display("FAIL load_priority: out_a=%0d tc_a=%b out_b=%0d tc_b=%b expected 12/0/12/0", out_a, tc_a, out_b, tc_b);
        end
        cyc();
        checks++;
        if (out_a !== 4'd0 || tc_a !== 1'b1) begin
            errors++;
            $display("FAIL load_out_of_range_step_a: out=%0d tc=%b expected 0/1", out_a, tc_a);
        end
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_out[k] !== 11'(m_out[k]) || obs_tc[k] !== m_tc[k] || obs_done[k] !== m_done[k]) begin
                    errors++;
                    $display("FAIL load_priority[%0d] c%0d: out=%0d tc=%b done=%b expected %0d/%b/%b", k, i, obs_out[k], obs_tc[k], obs_done[k], m_out[k], m_tc[k], m_done[k]);
                end
            end
            cyc();
        end
    endtask

    task automatic test_limit_zero_dirflip();
        int exp_a [4] = '{1, 2, 3, 2};
        limit = 0; value = 0; mode = 0; dir = 1'b1; en = 1'b1;
        load = 1'b1; cyc(); load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i >= 8) begin
                limit = 11'd7;
                dir   = (i == 11);
            end
            cyc();
            checks++;
            if (i < 8 && (out_a !== 4'd0 || tc_a !== 1'b1)) begin
                errors++;
                $display("FAIL limit_zero_a c%0d: out=%0d tc=%b expected 0/1", i, out_a, tc_a);
            end else if (i >= 8 && out_a !== 4'(exp_a[i-8])) begin
                errors++;
                $display("FAIL dir_flip_a c%0d: out=%0d expected %0d", i, out_a, exp_a[i-8]);
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_out[k] !== 11'(m_out[k]) || obs_tc[k] !== m_tc[k] || obs_done[k] !== m_done[k]) begin
                    errors++;
                    $display("FAIL limit_zero[%0d] c%0d: out=%0d tc=%b done=%b expected %0d/%b/%b", k, i, obs_out[k], obs_tc[k], obs_done[k], m_out[k], m_tc[k], m_done[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            load  = ($urandom % 12) == 0;
            en    = ($urandom % 4) != 0;
            dir   = ($urandom % 3) == 0 ? ~dir : dir;
            mode  = ($urandom % 8) == 0 ? ~mode : mode;
            value = 11'($urandom_range(0, 24));
            if (($urandom % 20) == 0) begin
                case ($urandom % 3)
                    0: limit = 11'd0;
                    1: limit = 11'd2047;
                    default: limit = 11'($urandom_range(0, 20));
                endcase
            end
            if (($urandom % 60) == 0) begin
                #2 rst = 1'b1;
                model_reset();
                #1;
                for (int k = 0; k < 2; k++) begin
                    checks++;
                    if (obs_out[k] !== 11'd0 || obs_tc[k] !== 1'b0 || obs_done[k] !== 1'b0) begin
                        errors++;
                        $display("FAIL random_async_reset[%0d] c%0d: out=%0d tc=%b done=%b expected 0/0/0", k, i, obs_out[k], obs_tc[k], obs_done[k]);
                    end
                end
                cyc();
                rst = 1'b0;
            end else begin
                cyc();
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_out[k] !== 11'(m_out[k]) || obs_tc[k] !== m_tc[k] || obs_done[k] !== m_done[k]) begin
                    errors++;
                    $display("FAIL random[%0d] c%0d: out=%0d tc=%b done=%b expected %0d/%b/%b", k, i, obs_out[k], obs_tc[k], obs_done[k], m_out[k], m_tc[k], m_done[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_oneshot();
        test_prescaler();
        test_load_priority();
        test_limit_zero_dirflip();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
